// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and defaults for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int SCAN_DIV_DEF        = 24000;
  localparam int DEBOUNCE_CYCLES_DEF = 480000;

  // KEYMAP[row][col]
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] first_low(input logic [3:0] i_rows);
    logic [1:0] w_idx;
    w_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!i_rows[k]) w_idx = 2'(k);
    end
    return w_idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// rtl/keypad_scanner_sync_2ff.sv - two-flop synchronizer, resets to all ones
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and two-digit history
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  state_t        r_state, w_state_n;
  logic [1:0]    r_col, w_col_n;
  logic [1:0]    r_row, w_row_n;
  logic [SW-1:0] r_scan_cnt, w_scan_cnt_n;
  logic [DW-1:0] r_deb_cnt, w_deb_cnt_n;
  logic          r_key_valid, w_key_valid_n;
  logic [3:0]    r_key_code, w_key_code_n;
  logic [3:0]    r_digit_new, w_digit_new_n;
  logic [3:0]    r_digit_old, w_digit_old_n;
  logic [3:0]    w_rs;
  logic          w_row_hi;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (rows),
    .o_q     (w_rs)
  );

  assign w_row_hi = w_rs[r_row];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= SCAN;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_scan_cnt  <= '0;
      r_deb_cnt   <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_digit_new <= 4'h0;
      r_digit_old <= 4'h0;
    end else begin
      r_state     <= w_state_n;
      r_col       <= w_col_n;
      r_row       <= w_row_n;
      r_scan_cnt  <= w_scan_cnt_n;
      r_deb_cnt   <= w_deb_cnt_n;
      r_key_valid <= w_key_valid_n;
      r_key_code  <= w_key_code_n;
      r_digit_new <= w_digit_new_n;
      r_digit_old <= w_digit_old_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_col_n       = r_col;
    w_row_n       = r_row;
    w_scan_cnt_n  = r_scan_cnt;
    w_deb_cnt_n   = r_deb_cnt;
    w_key_valid_n = 1'b0;
    w_key_code_n  = r_key_code;
    w_digit_new_n = r_digit_new;
    w_digit_old_n = r_digit_old;
    case (r_state)
      SCAN: begin
        // rows are only trusted on the last dwell cycle, after the column has settled
        if (r_scan_cnt == SCAN_LAST) begin
          w_scan_cnt_n = '0;
          if (!(&w_rs)) begin
            w_row_n     = first_low(w_rs);
            w_deb_cnt_n = '0;
            w_state_n   = DEBOUNCE;
          end else begin
            w_col_n = r_col + 2'd1;
          end
        end else begin
          w_scan_cnt_n = r_scan_cnt + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (w_row_hi) begin
          w_state_n    = SCAN;
          w_col_n      = r_col + 2'd1;
          w_scan_cnt_n = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_n     = HELD;
          w_key_valid_n = 1'b1;
          w_key_code_n  = KEYMAP[r_row][r_col];
          w_digit_new_n = KEYMAP[r_row][r_col];
          w_digit_old_n = r_digit_new;
        end else begin
          w_deb_cnt_n = r_deb_cnt + DW'(1);
        end
      end
      HELD: begin
        if (w_row_hi) begin
          w_deb_cnt_n = '0;
          w_state_n   = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_row_hi) begin
          w_state_n = HELD;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_n    = SCAN;
          w_col_n      = r_col + 2'd1;
          w_scan_cnt_n = '0;
        end else begin
          w_deb_cnt_n = r_deb_cnt + DW'(1);
        end
      end
      default: w_state_n = SCAN;
    endcase
  end

  assign cols      = ~(4'b0001 << r_col);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = (r_state == HELD) || (r_state == RELEASE);
  assign digit_new = r_digit_new;
  assign digit_old = r_digit_old;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;
  logic [15:0] keys;

  int n_cmp;
  int n_bad;
  int n_pulse;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keys[r*4+c] closed pulls row r low while column c is driven low
  always_comb begin
    for (int r = 0; r < 4; r++) rows[r] = ~|(keys[r*4 +: 4] & ~cols);
  end

  always @(negedge clk) if (key_valid === 1'b1) n_pulse++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cols(input logic [3:0] want, input string tag);
    int k;
    k = 0;
    do begin tick(); k++; end while (cols !== want && k < 64);
    check(tag, cols, want);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (key_valid !== 1'b1 && n < 200);
    check(tag, key_valid, 1);
  endtask

  task automatic wait_released(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (key_held !== 1'b0 && n < 200);
    check(tag, key_held, 0);
  endtask

  task automatic press_key(input int idx, input logic [3:0] code, input string tag);
    int n;
    keys[idx] = 1'b1;
    wait_valid({tag, "_valid"}, n);
    check({tag, "_code"}, key_code, code);
    repeat (10) tick();
    keys[idx] = 1'b0;
    wait_released({tag, "_rel"}, n);
  endtask

  initial begin
    int n;
    int p0;
    n_cmp   = 0;
    n_bad   = 0;
    n_pulse = 0;
    keys    = '0;
    reset   = 1'b0;

    // reset and free-running column walk
    repeat (3) tick();
    reset = 1'b1;
    check("rst_cols", cols, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    check("rst_new", digit_new, 0);
    check("rst_old", digit_old, 0);
    repeat (4) tick(); check("walk1", cols, 4'b1101);
    repeat (4) tick(); check("walk2", cols, 4'b1011);
    repeat (4) tick(); check("walk3", cols, 4'b0111);
    repeat (4) tick(); check("walk0", cols, 4'b1110);

    // key '5': debounce entry is 4 cycles after col1 drives, pulse 16 later
    p0 = n_pulse;
    keys[5] = 1'b1;
    wait_cols(4'b1101, "k5_col1");
    wait_valid("k5_valid", n);
    check("k5_latency", n, 20);
    check("k5_code", key_code, 4'h5);
    check("k5_new", digit_new, 4'h5);
    check("k5_old", digit_old, 4'h0);
    check("k5_held", key_held, 1);
    tick();
    check("k5_pulse_width", key_valid, 0);
    repeat (78) tick();
    check("k5_still_held", key_held, 1);
    keys[5] = 1'b0;
    wait_released("k5_release", n);
    check("k5_release_lat", n, 19);
    check("k5_resume_col2", cols, 4'b1011);
    check("k5_pulses", n_pulse - p0, 1);

    // short press of 8 cycles is rejected
    p0 = n_pulse;
    keys[5] = 1'b1;
    wait_cols(4'b1101, "bnc_col1");
    repeat (8) tick();
    keys[5] = 1'b0;
    repeat (2) tick();
    check("bnc_frozen", cols, 4'b1101);
    tick();
    check("bnc_next_col2", cols, 4'b1011);
    repeat (30) tick();
    check("bnc_pulses", n_pulse - p0, 0);

    // '1' then '9'
    p0 = n_pulse;
    press_key(0, 4'h1, "k1");
    press_key(10, 4'h9, "k9");
    check("k19_pulses", n_pulse - p0, 2);
    check("k19_new", digit_new, 4'h9);
    check("k19_old", digit_old, 4'h1);
    check("k19_code", key_code, 4'h9);

    // 'A' held, 'D' added in the same column, 'A' released first
    p0 = n_pulse;
    keys[3] = 1'b1;
    wait_valid("kA_valid", n);
    check("kA_code", key_code, 4'hA);
    repeat (5) tick();
    keys[15] = 1'b1;
    repeat (10) tick();
    check("kAD_code", key_code, 4'hA);
    keys[3] = 1'b0;
    wait_released("kA_release", n);
    check("kAD_pulses", n_pulse - p0, 1);
    keys[15] = 1'b0;
    repeat (60) tick();
    check("kAD_after", n_pulse - p0, 1);
    check("kAD_code_after", key_code, 4'hA);

    // '0' with release bounce
    p0 = n_pulse;
    keys[13] = 1'b1;
    wait_valid("k0_valid", n);
    check("k0_code", key_code, 4'h0);
    repeat (10) tick();
    for (int b = 0; b < 3; b++) begin
      keys[13] = 1'b0;
      repeat (5) tick();
      keys[13] = 1'b1;
      repeat (3) tick();
    end
    check("k0_bounce_held", key_held, 1);
    keys[13] = 1'b0;
    wait_released("k0_release", n);
    check("k0_pulses", n_pulse - p0, 1);
    check("k0_new", digit_new, 4'h0);
    check("k0_old", digit_old, 4'hA);

    // reset in the middle of a debounce
    keys[5] = 1'b1;
    wait_cols(4'b1101, "mr_col1");
    repeat (10) tick();
    p0 = n_pulse;
    reset = 1'b0;
    keys[5] = 1'b0;
    repeat (2) tick();
    check("mr_cols", cols, 4'b1110);
    check("mr_valid", key_valid, 0);
    check("mr_held", key_held, 0);
    check("mr_code", key_code, 0);
    check("mr_new", digit_new, 0);
    check("mr_old", digit_old, 0);
    reset = 1'b1;
    repeat (40) tick();
    check("mr_pulses", n_pulse - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
